// File: rtl/ku_aurora_boot_seq.sv
// Purpose : per-channel Aurora 64b66b bring-up/recovery sequencer (PMA_INIT -> RESET_PB -> CHANNEL_UP).
// Latency : all outputs registered; PMA_INIT falls PMA_DLY edges after S_PMA entry, RESET_PB PB_DLY after that.
// Backpr. : none; pure control block, inputs sampled every cycle, RESTART is a 1-cycle pulse.
//
// Ports:
//   clk100_i       system clock, all inputs synchronous to it
//   rst_i          synchronous active-high reset
//   dcm_locked_i   clock source locked; loss of lock parks every channel in S_IDLE
//   channel_up_i   per-channel Aurora CHANNEL_UP
//   restart_i      per-channel restart pulse (re-sequence from S_PMA)
//   pma_init_o     per-channel Aurora PMA_INIT
//   reset_pb_o     per-channel Aurora RESET_PB
//   ch_ready_o     per-channel link up and stable
//   ch_fail_o      per-channel retries exhausted
//   retry_cnt_o    per-channel consecutive-timeout count, channel i at [i*RW +: RW]
//   all_ready_o    registered AND of ch_ready_o
module ku_aurora_boot_seq #(
   parameter int N_CH      = 2,
   parameter int PMA_DLY   = 100,
   parameter int PB_DLY    = 100,
   parameter int UP_STABLE = 16,
   parameter int LINK_TO   = 65536,
   parameter int RETRY_MAX = 3,
   localparam int RW       = $clog2(RETRY_MAX + 1)
) (
   input  logic               clk100_i,
   input  logic               rst_i,
   input  logic               dcm_locked_i,
   input  logic [N_CH-1:0]    channel_up_i,
   input  logic [N_CH-1:0]    restart_i,
   output logic [N_CH-1:0]    pma_init_o,
   output logic [N_CH-1:0]    reset_pb_o,
   output logic [N_CH-1:0]    ch_ready_o,
   output logic [N_CH-1:0]    ch_fail_o,
   output logic [N_CH*RW-1:0] retry_cnt_o,
   output logic               all_ready_o
);

   // One shared counter per channel covers the longest of the three phases.
   localparam int DLY_MAX = (PMA_DLY > PB_DLY) ? PMA_DLY : PB_DLY;
   localparam int CNT_MAX = (DLY_MAX > LINK_TO) ? DLY_MAX : LINK_TO;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int SW      = $clog2(UP_STABLE + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PMA,
      S_PB,
      S_WAIT,
      S_UP,
      S_FAIL
   } state_t;

   logic [N_CH-1:0] rdy_vec;
   logic            all_ready_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      state_t        state_q;
      logic [CW-1:0] cnt_q;
      logic [SW-1:0] stab_q;
      logic [RW-1:0] retry_q;
      logic          pma_q;
      logic          pb_q;
      logic          rdy_q;
      logic          fail_q;

      always_ff @(posedge clk100_i) begin
         // Reset and lock loss share one action: everything back to the idle/held state.
         if (rst_i || !dcm_locked_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stab_q  <= '0;
            retry_q <= '0;
            pma_q   <= 1'b1;
            pb_q    <= 1'b1;
            rdy_q   <= 1'b0;
            fail_q  <= 1'b0;
         end else if (restart_i[i]) begin
            state_q <= S_PMA;
            cnt_q   <= '0;
            stab_q  <= '0;
            retry_q <= '0;
            pma_q   <= 1'b1;
            pb_q    <= 1'b1;
            rdy_q   <= 1'b0;
            fail_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  state_q <= S_PMA;
                  cnt_q   <= '0;
               end
               S_PMA: begin
                  if (cnt_q == CW'(PMA_DLY - 1)) begin
                     state_q <= S_PB;
                     cnt_q   <= '0;
                     pma_q   <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               S_PB: begin
                  if (cnt_q == CW'(PB_DLY - 1)) begin
                     state_q <= S_WAIT;
                     cnt_q   <= '0;
                     stab_q  <= '0;
                     pb_q    <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               S_WAIT: begin
                  // Ready is tested first so it wins over a timeout on the same edge.
                  if (channel_up_i[i] && (stab_q == SW'(UP_STABLE - 1))) begin
                     state_q <= S_UP;
                     cnt_q   <= '0;
                     stab_q  <= '0;
                     retry_q <= '0;
                     rdy_q   <= 1'b1;
                  end else if (cnt_q == CW'(LINK_TO - 1)) begin
                     cnt_q  <= '0;
                     stab_q <= '0;
                     pma_q  <= 1'b1;
                     pb_q   <= 1'b1;
                     if (retry_q == RW'(RETRY_MAX - 1)) begin
                        state_q <= S_FAIL;
                        retry_q <= RW'(RETRY_MAX);
                        fail_q  <= 1'b1;
                     end else begin
                        state_q <= S_PMA;
                        retry_q <= retry_q + 1'b1;
                     end
                  end else begin
                     // Timeout runs from entry regardless of CHANNEL_UP; stability needs an unbroken run.
                     cnt_q  <= cnt_q + 1'b1;
                     stab_q <= channel_up_i[i] ? stab_q + 1'b1 : '0;
                  end
               end
               S_UP: begin
                  if (!channel_up_i[i]) begin
                     state_q <= S_PMA;
                     cnt_q   <= '0;
                     pma_q   <= 1'b1;
                     pb_q    <= 1'b1;
                     rdy_q   <= 1'b0;
                  end
               end
               S_FAIL: begin
                  // Parked until restart, lock loss or reset.
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end

      assign pma_init_o[i]              = pma_q;
      assign reset_pb_o[i]              = pb_q;
      assign rdy_vec[i]                 = rdy_q;
      assign ch_fail_o[i]               = fail_q;
      assign retry_cnt_o[i*RW +: RW]    = retry_q;
   end

   always_ff @(posedge clk100_i) begin
      if (rst_i) begin
         all_ready_q <= 1'b0;
      end else begin
         all_ready_q <= &rdy_vec;
      end
   end

   assign ch_ready_o  = rdy_vec;
   assign all_ready_o = all_ready_q;

endmodule
